// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst read controller.
package fifo_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} rd_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO-ordered register buffer that catches words already in flight from the FIFO.
module rd_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] e0, e1;

  assign head_data = e0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          if (occ == 2'd0) e0 <= wr_data;
          else             e1 <= wr_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // simultaneous write/read keeps occupancy; new word lands behind the survivor
          if (occ == 2'(SKID_DEPTH)) begin
            e0 <= e1;
            e1 <= wr_data;
          end else begin
            e0 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops exactly cmd_len words from a 1-cycle-latency FIFO
// and streams them out on valid/ready, using a credit rule so the skid never overflows.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 128,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             fifo_read,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done
);
  rd_state_t        state;
  logic [LEN_W-1:0] rem_issue, rem_out;
  logic             inflight;
  logic             pop;
  logic [1:0]       occ;
  logic [2:0]       credit_used;

  rd_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inflight),
    .wr_data   (fifo_data),
    .rd_en     (pop),
    .head_data (out_data),
    .occ       (occ)
  );

  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid && out_ready;
  assign cmd_ready   = (state == IDLE);
  assign done        = (state == DONE);
  assign out_last    = out_valid && (rem_out == LEN_W'(1));
  assign credit_used = {1'b0, occ} + {2'b0, inflight};

  // Words buffered plus in flight, net of this cycle's pop, must stay below skid depth.
  // Held off during reset so no word is popped only to be discarded.
  assign fifo_read = rst && (state == BURST) && !fifo_empty && (rem_issue != '0) &&
                     (credit_used < 3'(SKID_DEPTH) + {2'b0, pop});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rem_issue <= '0;
      rem_out   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_read;
      if (fifo_read) rem_issue <= rem_issue - LEN_W'(1);
      if (pop)       rem_out   <= rem_out - LEN_W'(1);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rem_issue <= cmd_len;
            rem_out   <= cmd_len;
            state     <= (cmd_len == '0) ? DONE : BURST;
          end
        end
        BURST: if (pop && rem_out == LEN_W'(1)) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model plus a scoreboard of popped words.
module tb_fifo_burst_reader;
  localparam int WIDTH   = 32;
  localparam int MAX_LEN = 128;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             fifo_read;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .fifo_read  (fifo_read),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done       (done)
  );

  typedef struct {
    int len;
    int rmode;      // 0 always ready, 1 toggling, 2 random
    int smode;      // 0 no stall, 1 five-cycle stall after 2 words, 2 random stalls
    int base;       // nonzero: words are base+1, base+2, ...
    int exp_rd;     // expected cycle index of first fifo_read (-9 = unchecked)
    int exp_valid;  // expected cycle index of first out_valid
    int exp_done;   // expected cycle index of done
  } vec_t;

  int errors = 0, checks = 0;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  int  n_pops = 0, n_hs = 0, blen = 0, cyc = 0, stall_left = 0;
  int  first_rd = -1, first_valid = -1, done_idx = -1;
  bit  stall = 0, done_due = 0, hold = 0, busy = 0, stall_used = 0;
  logic [WIDTH-1:0] hold_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: check at negedge, model the FIFO pop just after posedge.
  task automatic cycle();
    bit rd, hs, acc;
    logic [WIDTH-1:0] w;
    fifo_empty = stall || (fq.size() == 0);
    @(negedge clk);
    cyc++;
    rd = fifo_read;
    hs = out_valid && out_ready;
    if (rst) begin
      acc = cmd_valid && !busy;
      chk("cmd_ready", cmd_ready, !busy);
      chk("done", done, done_due);
      if (done_due) begin done_idx = cyc; busy = 0; end
      done_due = 0;
      if (rd) begin
        chk("read_while_empty", fifo_empty, 0);
        chk("outstanding_le2", (n_pops + 1 - n_hs - int'(hs)) <= 2, 1);
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (hs) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("out_data", out_data, w);
        end
        chk("out_last", out_last, (n_hs + 1) == blen);
        n_hs++;
        done_due = (n_hs == blen);
      end
      if (acc) begin
        busy = 1; blen = int'(cmd_len); n_hs = 0; n_pops = 0; cyc = 0;
        done_due = (cmd_len == '0);
        first_rd = -1; first_valid = -1; done_idx = -1;
      end
      if (rd && first_rd < 0) first_rd = cyc;
      if (out_valid && first_valid < 0) first_valid = cyc;
    end
    @(posedge clk);
    #1;
    if (rst && rd && fq.size() != 0) begin
      w = fq.pop_front();
      fifo_data = w;
      exp_q.push_back(w);
      n_pops++;
    end
    fifo_empty = stall || (fq.size() == 0);
  endtask

  task automatic load(input vec_t v);
    fq.delete();
    for (int i = 0; i < v.len; i++)
      fq.push_back(v.base != 0 ? WIDTH'(v.base + i + 1) : $urandom);
  endtask

  task automatic drive_cycle(input vec_t v, input int k);
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_len   = LEN_W'($urandom_range(0, 255));
    case (v.rmode)
      0: out_ready = 1'b1;
      1: out_ready = k[0];
      default: out_ready = ($urandom_range(0, 99) < 70);
    endcase
    if (v.smode == 1 && !stall_used && n_hs == 2) begin
      stall_left = 5; stall_used = 1;
    end else if (v.smode == 2) begin
      stall_left = ($urandom_range(0, 3) == 0) ? 1 : 0;
    end
    stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    cycle();
  endtask

  task automatic run_burst(input vec_t v);
    load(v);
    stall = 0; stall_left = 0; stall_used = 0;
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(v.len);
    cycle();
    chk("accepted", busy || done_due, 1);
    for (int k = 0; k < v.len * 20 + 60 && busy; k++) drive_cycle(v, k);
    chk("burst_timeout", busy, 0);
    cmd_valid = 1'b0;
    stall = 0;
    cycle();
    chk("words", n_hs, v.len);
    chk("pops", n_pops, v.len);
    chk("residue", exp_q.size(), 0);
    if (v.exp_rd != -9) begin
      chk("first_read_idx", first_rd, v.exp_rd);
      chk("first_valid_idx", first_valid, v.exp_valid);
      chk("done_idx", done_idx, v.exp_done);
    end
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    vecs.push_back('{len: 4,       rmode: 0, smode: 0, base: 'h10, exp_rd: 1,  exp_valid: 3,  exp_done: 7});
    vecs.push_back('{len: 0,       rmode: 0, smode: 0, base: 0,    exp_rd: -1, exp_valid: -1, exp_done: 1});
    vecs.push_back('{len: 8,       rmode: 1, smode: 0, base: 'h40, exp_rd: -9, exp_valid: 0,  exp_done: 0});
    vecs.push_back('{len: 6,       rmode: 0, smode: 1, base: 'h60, exp_rd: -9, exp_valid: 0,  exp_done: 0});
    vecs.push_back('{len: 1,       rmode: 0, smode: 0, base: 0,    exp_rd: 1,  exp_valid: 3,  exp_done: 4});
    vecs.push_back('{len: MAX_LEN, rmode: 0, smode: 0, base: 0,    exp_rd: 1,  exp_valid: 3,  exp_done: MAX_LEN + 3});
    vecs.push_back('{len: 2,       rmode: 1, smode: 2, base: 0,    exp_rd: -9, exp_valid: 0,  exp_done: 0});

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset while the third word of a 10-word burst is presented
    rv = '{len: 10, rmode: 0, smode: 0, base: 'h80, exp_rd: -9, exp_valid: 0, exp_done: 0};
    load(rv);
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(10);
    cycle();
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && !(n_hs == 2 && out_valid); k++) cycle();
    chk("reached_word3", n_hs == 2 && out_valid, 1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    fq.delete(); exp_q.delete();
    busy = 0; done_due = 0; hold = 0; n_hs = 0; n_pops = 0;
    fifo_empty = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_done", done, 0);
    @(posedge clk);
    #1;
    rv = '{len: 2, rmode: 0, smode: 0, base: 'hA0, exp_rd: 1, exp_valid: 3, exp_done: 5};
    run_burst(rv);

    for (int r = 0; r < 25; r++) begin
      rv = '{len: $urandom_range(0, 20), rmode: 2, smode: 2, base: 0,
             exp_rd: -9, exp_valid: 0, exp_done: 0};
      run_burst(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
